// File: rtl/tlm_arbiter.sv
// tlm_arbiter: weighted two-source arbiter in front of the TLM tx link.
// Local responses and forwarded remote telemetry share one output register.
// Remote packets get their hop-count target incremented on the way through;
// a remote packet whose target is already all-ones is consumed and counted
// as a drop instead of being forwarded.
module tlm_arbiter #(
    parameter int TARGET_W      = 8,
    parameter int PAYLOAD_W     = 48,
    parameter int LOCAL_WEIGHT  = 1,
    parameter int REMOTE_WEIGHT = 4
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [PAYLOAD_W-1:0]          loc_payload_i,
    input  logic                          loc_val_i,
    output logic                          loc_rdy_o,
    input  logic [TARGET_W+PAYLOAD_W-1:0] rem_data_i,
    input  logic                          rem_val_i,
    output logic                          rem_rdy_o,
    output logic [TARGET_W+PAYLOAD_W-1:0] out_data_o,
    output logic                          out_wr_o,
    input  logic                          out_rdy_i,
    output logic [15:0]                   drop_count_o,
    output logic                          last_src_o
);

    localparam int BURST_MAX = (LOCAL_WEIGHT > REMOTE_WEIGHT) ? LOCAL_WEIGHT : REMOTE_WEIGHT;
    localparam int BURST_W   = $clog2(BURST_MAX + 1);
    localparam logic [BURST_W-1:0] LW_B   = BURST_W'(LOCAL_WEIGHT);
    localparam logic [BURST_W-1:0] RW_B   = BURST_W'(REMOTE_WEIGHT);
    localparam logic [BURST_W-1:0] BMAX_B = BURST_W'(BURST_MAX);
    localparam int DATA_W = TARGET_W + PAYLOAD_W;

    typedef enum logic {
        LAST_LOC = 1'b0,
        LAST_REM = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_wr_q, out_wr_d;
    logic [15:0]          drop_q, drop_d;

    logic                 slot_free;
    logic                 gnt_loc, gnt_rem, rem_drop;
    logic [TARGET_W-1:0]  rem_target;
    logic [PAYLOAD_W-1:0] rem_payload;

    assign rem_target  = rem_data_i[DATA_W-1:PAYLOAD_W];
    assign rem_payload = rem_data_i[PAYLOAD_W-1:0];
    // The slot can take a new packet if empty or emptying this cycle.
    assign slot_free   = !out_wr_q || out_rdy_i;

    // State register: arbitration state, burst count, output slot, drop counter.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= LAST_REM;
            burst_q    <= RW_B;
            out_data_q <= '0;
            out_wr_q   <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            out_data_q <= out_data_d;
            out_wr_q   <= out_wr_d;
            drop_q     <= drop_d;
        end
    end

    // Grant selection and next-state for arbitration state and burst count.
    always_comb begin
        gnt_loc = 1'b0;
        gnt_rem = 1'b0;
        state_d = state_q;
        burst_d = burst_q;
        if (!reset_i && slot_free) begin
            if (loc_val_i && rem_val_i) begin
                if (state_q == LAST_LOC) gnt_loc = (burst_q < LW_B);
                else                     gnt_loc = !(burst_q < RW_B);
                gnt_rem = !gnt_loc;
            end else begin
                gnt_loc = loc_val_i;
                gnt_rem = rem_val_i;
            end
        end
        if (gnt_loc || gnt_rem) begin
            if ((gnt_rem ? LAST_REM : LAST_LOC) == state_q) begin
                burst_d = (burst_q == BMAX_B) ? burst_q : burst_q + 1'b1;
            end else begin
                state_d = gnt_rem ? LAST_REM : LAST_LOC;
                burst_d = BURST_W'(1);
            end
        end
    end

    // Output slot load/drain and drop accounting.
    always_comb begin
        out_data_d = out_data_q;
        out_wr_d   = out_wr_q;
        drop_d     = drop_q;
        rem_drop   = gnt_rem && (&rem_target);
        if (gnt_loc) begin
            out_data_d = {TARGET_W'(0), loc_payload_i};
            out_wr_d   = 1'b1;
        end else if (gnt_rem && !rem_drop) begin
            out_data_d = {rem_target + 1'b1, rem_payload};
            out_wr_d   = 1'b1;
        end else if (out_rdy_i) begin
            // Either idle or the held packet left this cycle; a drop lands here too.
            out_wr_d = 1'b0;
        end
        if (rem_drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    assign loc_rdy_o    = gnt_loc;
    assign rem_rdy_o    = gnt_rem;
    assign out_data_o   = out_data_q;
    assign out_wr_o     = out_wr_q;
    assign drop_count_o = drop_q;
    assign last_src_o   = state_q;

endmodule

// File: tb/tb_tlm_arbiter.sv
// Directed bench for tlm_arbiter with a scoreboard of forwarded packets.
module tb_tlm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] loc_payload;
    logic        loc_val, loc_rdy;
    logic [55:0] rem_data;
    logic        rem_val, rem_rdy;
    logic [55:0] out_data;
    logic        out_wr, out_rdy;
    logic [15:0] drop_count;
    logic        last_src;

    int n_tests = 0;
    int n_fail  = 0;

    logic [55:0] sb[$];
    logic [55:0] sb_exp;
    logic [55:0] saved;
    logic [7:0]  mon_tgt;
    logic        exp_loc [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    tlm_arbiter #(
        .TARGET_W(8), .PAYLOAD_W(48), .LOCAL_WEIGHT(1), .REMOTE_WEIGHT(4)
    ) dut (
        .clock_i(clk), .reset_i(reset),
        .loc_payload_i(loc_payload), .loc_val_i(loc_val), .loc_rdy_o(loc_rdy),
        .rem_data_i(rem_data), .rem_val_i(rem_val), .rem_rdy_o(rem_rdy),
        .out_data_o(out_data), .out_wr_o(out_wr), .out_rdy_i(out_rdy),
        .drop_count_o(drop_count), .last_src_o(last_src)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push what was accepted, pop and compare on each transfer.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_wr && out_rdy) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    sb_exp = sb.pop_front();
                    chk("sb_data", 64'(out_data), 64'(sb_exp));
                end
            end
            if (loc_val && loc_rdy) sb.push_back({8'h00, loc_payload});
            if (rem_val && rem_rdy) begin
                mon_tgt = rem_data[55:48];
                if (mon_tgt != 8'hFF) sb.push_back({mon_tgt + 8'd1, rem_data[47:0]});
            end
        end
    end

    initial begin
        reset = 1'b1; loc_payload = '0; loc_val = 1'b1; rem_data = '0; rem_val = 1'b0; out_rdy = 1'b1;
        // Reset state
        tick(); tick();
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_last_src", 64'(last_src), 64'd1);
        chk("rst_loc_rdy", 64'(loc_rdy), 64'd0);
        loc_val = 1'b0; reset = 1'b0;
        tick();

        // Single local packet
        loc_payload = 48'h123456789ABC; loc_val = 1'b1;
        #1;
        chk("loc_rdy", 64'(loc_rdy), 64'd1);
        chk("loc_rem_rdy", 64'(rem_rdy), 64'd0);
        tick();
        loc_val = 1'b0;
        chk("loc_out_wr", 64'(out_wr), 64'd1);
        chk("loc_out_data", 64'(out_data), 64'h00_123456789ABC);
        chk("loc_last_src", 64'(last_src), 64'd0);

        // Back-to-back remote packets
        rem_data = {8'h05, 48'hA0A1A2A3A4A5}; rem_val = 1'b1;
        #1;
        chk("rem_rdy0", 64'(rem_rdy), 64'd1);
        tick();
        chk("rem_out0", 64'(out_data), 64'h06_A0A1A2A3A4A5);
        rem_data = {8'h07, 48'h0000DEADBEEF};
        #1;
        chk("rem_rdy1", 64'(rem_rdy), 64'd1);
        tick();
        rem_val = 1'b0;
        chk("rem_out1", 64'(out_data), 64'h08_0000DEADBEEF);
        chk("rem_out_wr1", 64'(out_wr), 64'd1);
        tick();
        chk("rem_idle_wr", 64'(out_wr), 64'd0);

        // Weighted arbitration from a fresh reset
        reset = 1'b1; tick(); reset = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            loc_payload = 48'(64'h111100000000 + i);
            rem_data    = {8'h10, 48'(1000 + i)};
            loc_val = 1'b1; rem_val = 1'b1;
            #1;
            chk($sformatf("arb_loc_rdy%0d", i), 64'(loc_rdy), 64'(exp_loc[i]));
            chk($sformatf("arb_rem_rdy%0d", i), 64'(rem_rdy), 64'(!exp_loc[i]));
            tick();
            chk($sformatf("arb_last_src%0d", i), 64'(last_src), 64'(!exp_loc[i]));
        end

        // Backpressure: output held, no grants
        out_rdy = 1'b0;
        saved = {8'h11, 48'(1009)};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_loc_rdy", 64'(loc_rdy), 64'd0);
            chk("stall_rem_rdy", 64'(rem_rdy), 64'd0);
            tick();
            chk("stall_data", 64'(out_data), 64'(saved));
            chk("stall_wr", 64'(out_wr), 64'd1);
        end
        out_rdy = 1'b1;
        #1;
        chk("unstall_grant_loc", 64'(loc_rdy), 64'd1);
        tick();
        loc_val = 1'b0; rem_val = 1'b0;
        chk("unstall_data", 64'(out_data), {8'h00, 8'h00, loc_payload});
        tick();
        chk("drain_wr", 64'(out_wr), 64'd0);

        // Target-overflow drops
        rem_data = {8'hFF, 48'hCAFE00000001}; rem_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drop_rdy", 64'(rem_rdy), 64'd1);
            tick();
            chk("drop_no_wr", 64'(out_wr), 64'd0);
        end
        rem_val = 1'b0;
        chk("drop_cnt3", 64'(drop_count), 64'd3);
        // Drop while the slot drains: out_wr must fall
        loc_payload = 48'h0000ABCDEF01; loc_val = 1'b1;
        tick();
        loc_val = 1'b0; rem_val = 1'b1;
        chk("drain_drop_wr_before", 64'(out_wr), 64'd1);
        #1;
        chk("drain_drop_rdy", 64'(rem_rdy), 64'd1);
        tick();
        chk("drain_drop_wr_after", 64'(out_wr), 64'd0);
        chk("drop_cnt4", 64'(drop_count), 64'd4);
        // Saturation
        repeat (65531) tick();
        chk("drop_cnt_max", 64'(drop_count), 64'hFFFF);
        tick();
        rem_val = 1'b0;
        chk("drop_cnt_sat", 64'(drop_count), 64'hFFFF);

        // Reset mid-stream
        out_rdy = 1'b0;
        loc_payload = 48'h0000FEEDF00D; loc_val = 1'b1;
        tick();
        chk("pre_rst_wr", 64'(out_wr), 64'd1);
        rem_data = {8'h20, 48'h000000000042}; rem_val = 1'b1; reset = 1'b1;
        #1;
        chk("in_rst_loc_rdy", 64'(loc_rdy), 64'd0);
        chk("in_rst_rem_rdy", 64'(rem_rdy), 64'd0);
        tick();
        chk("mid_rst_wr", 64'(out_wr), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_drop", 64'(drop_count), 64'd0);
        chk("mid_rst_last_src", 64'(last_src), 64'd1);
        reset = 1'b0; out_rdy = 1'b1;
        #1;
        chk("post_rst_loc_first", 64'(loc_rdy), 64'd1);
        chk("post_rst_rem_wait", 64'(rem_rdy), 64'd0);
        tick();
        loc_val = 1'b0; rem_val = 1'b0;
        chk("post_rst_data", 64'(out_data), 64'h00_0000FEEDF00D);
        tick(); tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
